// File: rtl/ram_arbiter_if.sv
// Bundle of the three master ports and the single-port RAM port of ram_arbiter.
// slave = the arbiter's view; master = the view of whatever drives the masters and models the RAM.
interface ram_arbiter_if;
    logic        m0_req_i, m0_we_i, m0_ack_o;
    logic [3:0]  m0_be_i;
    logic [31:0] m0_addr_i, m0_data_i, m0_data_o;
    logic        m1_req_i, m1_we_i, m1_ack_o;
    logic [3:0]  m1_be_i;
    logic [31:0] m1_addr_i, m1_data_i, m1_data_o;
    logic        m2_req_i, m2_we_i, m2_ack_o;
    logic [3:0]  m2_be_i;
    logic [31:0] m2_addr_i, m2_data_i, m2_data_o;
    logic        ram_req_o, ram_we_o;
    logic [31:0] ram_addr_o, ram_data_o, ram_data_i;

    modport slave (
        input  m0_req_i, m0_we_i, m0_be_i, m0_addr_i, m0_data_i,
        input  m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_data_i,
        input  m2_req_i, m2_we_i, m2_be_i, m2_addr_i, m2_data_i,
        output m0_data_o, m0_ack_o, m1_data_o, m1_ack_o, m2_data_o, m2_ack_o,
        output ram_req_o, ram_we_o, ram_addr_o, ram_data_o,
        input  ram_data_i
    );

    modport master (
        output m0_req_i, m0_we_i, m0_be_i, m0_addr_i, m0_data_i,
        output m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_data_i,
        output m2_req_i, m2_we_i, m2_be_i, m2_addr_i, m2_data_i,
        input  m0_data_o, m0_ack_o, m1_data_o, m1_ack_o, m2_data_o, m2_ack_o,
        input  ram_req_o, ram_we_o, ram_addr_o, ram_data_o,
        output ram_data_i
    );
endinterface

// File: rtl/ram_arbiter.sv
// Three-master arbiter for a single-port word RAM; sub-word writes become
// read-modify-write so the RAM only ever sees whole-word writes.
module ram_arbiter_lane (
    input  logic       be,
    input  logic [7:0] wr_byte,
    input  logic [7:0] old_byte,
    output logic [7:0] merged
);
    assign merged = be ? wr_byte : old_byte;
endmodule

module ram_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    ram_arbiter_if.slave bus
);
    localparam int NM = 3;
    localparam int NB = 4;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] MERGE  = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    logic [NM-1:0]          req, we;
    logic [NM-1:0][NB-1:0]  be;
    logic [NM-1:0][31:0]    addr, wdata;

    assign req   = {bus.m2_req_i,  bus.m1_req_i,  bus.m0_req_i};
    assign we    = {bus.m2_we_i,   bus.m1_we_i,   bus.m0_we_i};
    assign be    = {bus.m2_be_i,   bus.m1_be_i,   bus.m0_be_i};
    assign addr  = {bus.m2_addr_i, bus.m1_addr_i, bus.m0_addr_i};
    assign wdata = {bus.m2_data_i, bus.m1_data_i, bus.m0_data_i};

    logic [1:0]          state, last, win, grant;
    logic [2:0]          cand;
    logic                lat_we;
    logic [NB-1:0]       lat_be;
    logic [31:0]         lat_addr, lat_data, merge_q, merged, ram_wdata;
    logic [NM-1:0][31:0] rdata_q;
    logic [NM-1:0]       ack;
    logic                full_w, part_w;

    assign full_w = lat_we && (lat_be == 4'hF);
    assign part_w = lat_we && (lat_be != 4'hF) && (lat_be != 4'h0);

    // Round-robin walks last+3 down to last+1 so the nearest requester after last wins.
    always_comb begin
        grant = 2'd0;
        cand  = 3'd0;
        if (RR_EN) begin
            for (int i = NM; i >= 1; i--) begin
                cand = {1'b0, last} + 3'(i);
                if (cand >= 3'd3)
                    cand = cand - 3'd3;
                if (req[cand[1:0]])
                    grant = cand[1:0];
            end
        end else begin
            for (int i = NM - 1; i >= 0; i--)
                if (req[i])
                    grant = 2'(i);
        end
    end

    for (genvar k = 0; k < NB; k++) begin : g_lane
        ram_arbiter_lane u_lane (
            .be       (lat_be[k]),
            .wr_byte  (lat_data[8*k +: 8]),
            .old_byte (merge_q[8*k +: 8]),
            .merged   (merged[8*k +: 8])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last     <= 2'd2;
            win      <= 2'd0;
            lat_we   <= 1'b0;
            lat_be   <= '0;
            lat_addr <= '0;
            lat_data <= '0;
            merge_q  <= '0;
            rdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        win      <= grant;
                        last     <= grant;
                        lat_we   <= we[grant];
                        lat_be   <= be[grant];
                        lat_addr <= addr[grant];
                        lat_data <= wdata[grant];
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!lat_we) begin
                        rdata_q[win] <= bus.ram_data_i;
                        state        <= RESP;
                    end else if (part_w) begin
                        merge_q <= bus.ram_data_i;
                        state   <= MERGE;
                    end else begin
                        state <= RESP;
                    end
                end
                MERGE:   state <= RESP;
                default: state <= IDLE;
            endcase
        end
    end

    // Reset gates the RAM strobes combinationally so an abort never commits a write.
    always_comb begin
        ram_wdata = '0;
        if (state == ACCESS && full_w)
            ram_wdata = lat_data;
        else if (state == MERGE)
            ram_wdata = merged;
    end

    assign bus.ram_req_o  = !rst && (state == ACCESS || state == MERGE);
    assign bus.ram_we_o   = !rst && ((state == ACCESS && full_w) || state == MERGE);
    assign bus.ram_addr_o = lat_addr;
    assign bus.ram_data_o = ram_wdata;

    for (genvar m = 0; m < NM; m++) begin : g_ack
        assign ack[m] = !rst && (state == RESP) && (win == 2'(m));
    end

    assign bus.m0_ack_o  = ack[0];
    assign bus.m1_ack_o  = ack[1];
    assign bus.m2_ack_o  = ack[2];
    assign bus.m0_data_o = rdata_q[0];
    assign bus.m1_data_o = rdata_q[1];
    assign bus.m2_data_o = rdata_q[2];
endmodule
